// File: rtl/ahb_mtx_decoder_param.sv
// Input-stage address decoder for the AHB bus matrix: routes each transfer to one of
// NUM_PORTS output stages or the built-in default slave. Optional macro: AHB_DEC_ERR_CAPTURE_EN.
module ahb_mtx_decoder_param #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_LSB  = 10,
  parameter logic [NUM_PORTS*(32-ADDR_LSB)-1:0] REGION_BASE = {
    (32-ADDR_LSB)'(32'h5000_0000 >> ADDR_LSB),
    (32-ADDR_LSB)'(32'h6000_0000 >> ADDR_LSB),
    (32-ADDR_LSB)'(32'h4000_0000 >> ADDR_LSB),
    (32-ADDR_LSB)'(32'h2000_0000 >> ADDR_LSB)},
  parameter logic [NUM_PORTS*(32-ADDR_LSB)-1:0] REGION_LIMIT = {
    (32-ADDR_LSB)'(32'h5FFF_FFFF >> ADDR_LSB),
    (32-ADDR_LSB)'(32'h9FFF_FFFF >> ADDR_LSB),
    (32-ADDR_LSB)'(32'h4FFF_FFFF >> ADDR_LSB),
    (32-ADDR_LSB)'(32'h2000_FFFF >> ADDR_LSB)}
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      sel_i,
  input  logic [31-ADDR_LSB:0]      addr_i,
  input  logic [1:0]                trans_i,
  input  logic                      readys_i,
  input  logic [NUM_PORTS-1:0]      active_i,
  input  logic [NUM_PORTS-1:0]      readyout_i,
  input  logic [2*NUM_PORTS-1:0]    resp_i,
  input  logic [32*NUM_PORTS-1:0]   rdata_i,
  input  logic [32*NUM_PORTS-1:0]   ruser_i,
  output logic [NUM_PORTS-1:0]      sel_o,
  output logic                      active_o,
  output logic                      readyout_o,
  output logic [1:0]                resp_o,
  output logic [31:0]               rdata_o,
  output logic [31:0]               ruser_o,
  input  logic                      err_clr_i,
  output logic                      err_valid_o,
  output logic [31-ADDR_LSB:0]      err_addr_o
);

  localparam int DW = 32 - ADDR_LSB;

  // Port encoding: 0..7 are output stages, then the default slave and "no data phase".
  localparam logic [3:0] PORT_DFT  = 4'd8;
  localparam logic [3:0] PORT_NONE = 4'd9;

  typedef enum logic [1:0] {
    DFT_IDLE = 2'd0,
    DFT_ERR1 = 2'd1,
    DFT_ERR2 = 2'd2
  } dft_state_e;

  logic [3:0]           match_port_s;
  logic                 match_found_s;
  logic                 hold_s;
  logic [3:0]           addr_port_s;
  logic                 dft_qual_s;
  logic [3:0]           data_port_q, data_port_d;
  dft_state_e           dft_state_q, dft_state_d;
  logic                 dft_ready_s;
  logic [1:0]           dft_resp_s;
  logic [NUM_PORTS-1:0] dsel_s;
  logic                 slv_ready_s;
  logic [1:0]           slv_resp_s;
  logic [31:0]          rdata_s;
  logic [31:0]          ruser_s;

  // Region match: the lowest-indexed matching region wins, no match goes to the default slave.
  always_comb begin
    match_port_s  = PORT_DFT;
    match_found_s = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!match_found_s &&
          (addr_i >= REGION_BASE[p*DW +: DW]) &&
          (addr_i <= REGION_LIMIT[p*DW +: DW])) begin
        match_port_s  = 4'(p);
        match_found_s = 1'b1;
      end else begin
        match_found_s = match_found_s;
      end
    end
  end

  // An IDLE cycle keeps pointing at the port owning the data phase so its HSEL stays stable.
  assign hold_s      = (trans_i == 2'b00) && (data_port_q < 4'(NUM_PORTS));
  assign addr_port_s = hold_s ? data_port_q : match_port_s;
  assign dft_qual_s  = sel_i && (addr_port_s == PORT_DFT) && trans_i[1] && readys_i;

  // Per-output select and the active flag of the address-phase target.
  always_comb begin
    sel_o    = '0;
    active_o = (addr_port_s == PORT_DFT);
    for (int p = 0; p < NUM_PORTS; p++) begin
      sel_o[p] = sel_i && (addr_port_s == 4'(p));
      active_o = active_o | ((addr_port_s == 4'(p)) & active_i[p]);
    end
  end

  // Data-phase owner advances only when the input stage accepts an address phase.
  always_comb begin
    if (readys_i) begin
      data_port_d = sel_i ? addr_port_s : PORT_NONE;
    end else begin
      data_port_d = data_port_q;
    end
  end

  // Data-phase owner register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      data_port_q <= PORT_NONE;
    end else begin
      data_port_q <= data_port_d;
    end
  end

  // Default-slave next state; ERR1 always advances so the error response cannot stall.
  always_comb begin
    dft_state_d = dft_state_q;
    case (dft_state_q)
      DFT_IDLE: begin
        if (dft_qual_s) begin
          dft_state_d = DFT_ERR1;
        end else begin
          dft_state_d = DFT_IDLE;
        end
      end
      DFT_ERR1: begin
        dft_state_d = DFT_ERR2;
      end
      DFT_ERR2: begin
        if (dft_qual_s) begin
          dft_state_d = DFT_ERR1;
        end else if (readys_i) begin
          dft_state_d = DFT_IDLE;
        end else begin
          dft_state_d = DFT_ERR2;
        end
      end
      default: begin
        dft_state_d = DFT_IDLE;
      end
    endcase
  end

  // Default-slave state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dft_state_q <= DFT_IDLE;
    end else begin
      dft_state_q <= dft_state_d;
    end
  end

  // Default-slave response: two-cycle ERROR, otherwise zero-wait OKAY.
  always_comb begin
    dft_ready_s = 1'b1;
    dft_resp_s  = 2'b00;
    case (dft_state_q)
      DFT_IDLE: begin
        dft_ready_s = 1'b1;
        dft_resp_s  = 2'b00;
      end
      DFT_ERR1: begin
        dft_ready_s = 1'b0;
        dft_resp_s  = 2'b01;
      end
      DFT_ERR2: begin
        dft_ready_s = 1'b1;
        dft_resp_s  = 2'b01;
      end
      default: begin
        dft_ready_s = 1'b1;
        dft_resp_s  = 2'b00;
      end
    endcase
  end

  // One-hot AND-OR return mux; an all-zero select yields zero data for NONE/DFT.
  always_comb begin
    dsel_s      = '0;
    slv_ready_s = 1'b0;
    slv_resp_s  = 2'b00;
    rdata_s     = 32'h0000_0000;
    ruser_s     = 32'h0000_0000;
    for (int p = 0; p < NUM_PORTS; p++) begin
      dsel_s[p]   = (data_port_q == 4'(p));
      slv_ready_s = slv_ready_s | (dsel_s[p] & readyout_i[p]);
      slv_resp_s  = slv_resp_s  | ({2{dsel_s[p]}} & resp_i[p*2 +: 2]);
      rdata_s     = rdata_s     | ({32{dsel_s[p]}} & rdata_i[p*32 +: 32]);
      ruser_s     = ruser_s     | ({32{dsel_s[p]}} & ruser_i[p*32 +: 32]);
    end
  end

  // Ready/response source selection for the data phase.
  always_comb begin
    readyout_o = 1'b1;
    resp_o     = 2'b00;
    case (data_port_q)
      PORT_NONE: begin
        readyout_o = 1'b1;
        resp_o     = 2'b00;
      end
      PORT_DFT: begin
        readyout_o = dft_ready_s;
        resp_o     = dft_resp_s;
      end
      default: begin
        readyout_o = slv_ready_s;
        resp_o     = slv_resp_s;
      end
    endcase
  end

  assign rdata_o = rdata_s;
  assign ruser_o = ruser_s;

`ifdef AHB_DEC_ERR_CAPTURE_EN
  logic          err_valid_q, err_valid_d;
  logic [DW-1:0] err_addr_q, err_addr_d;

  // First unmapped access is kept until cleared; a new error in the clear cycle is recaptured.
  always_comb begin
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    if (dft_qual_s && (!err_valid_q || err_clr_i)) begin
      err_valid_d = 1'b1;
      err_addr_d  = addr_i;
    end else if (err_clr_i) begin
      err_valid_d = 1'b0;
    end else begin
      err_valid_d = err_valid_q;
    end
  end

  // Error capture registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign err_valid_o = err_valid_q;
  assign err_addr_o  = err_addr_q;
`else
  logic unused_err_clr_s;

  assign unused_err_clr_s = err_clr_i;
  assign err_valid_o      = 1'b0;
  assign err_addr_o       = '0;
`endif

endmodule

// File: tb/tb_ahb_mtx_decoder_param.sv
// Directed bench for ahb_mtx_decoder_param: default map plus an overlapping-region instance.
module tb_ahb_mtx_decoder_param;

`ifdef AHB_DEC_ERR_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic         sel_i;
  logic [21:0]  addr_i;
  logic [1:0]   trans_i;
  logic         readys_i;
  logic [3:0]   active_i;
  logic [3:0]   readyout_i;
  logic [7:0]   resp_i;
  logic [127:0] rdata_i;
  logic [127:0] ruser_i;
  logic         err_clr_i;

  logic [3:0]   sel_o, ovl_sel_o;
  logic         active_o, ovl_active_o;
  logic         readyout_o, ovl_readyout_o;
  logic [1:0]   resp_o, ovl_resp_o;
  logic [31:0]  rdata_o, ovl_rdata_o;
  logic [31:0]  ruser_o, ovl_ruser_o;
  logic         err_valid_o, ovl_err_valid_o;
  logic [21:0]  err_addr_o, ovl_err_addr_o;

  int n_vec;
  int n_err;

  always #5 HCLK = ~HCLK;

  ahb_mtx_decoder_param u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .sel_i(sel_i), .addr_i(addr_i), .trans_i(trans_i),
    .readys_i(readys_i), .active_i(active_i), .readyout_i(readyout_i), .resp_i(resp_i),
    .rdata_i(rdata_i), .ruser_i(ruser_i), .sel_o(sel_o), .active_o(active_o),
    .readyout_o(readyout_o), .resp_o(resp_o), .rdata_o(rdata_o), .ruser_o(ruser_o),
    .err_clr_i(err_clr_i), .err_valid_o(err_valid_o), .err_addr_o(err_addr_o)
  );

  // Region 1 moved down onto region 0's base: 0x20000000 overlaps both.
  ahb_mtx_decoder_param #(
    .REGION_BASE({22'(32'h5000_0000 >> 10), 22'(32'h6000_0000 >> 10),
                  22'(32'h2000_0000 >> 10), 22'(32'h2000_0000 >> 10)})
  ) u_dut_ovl (
    .HCLK(HCLK), .HRESETn(HRESETn), .sel_i(sel_i), .addr_i(addr_i), .trans_i(trans_i),
    .readys_i(readys_i), .active_i(active_i), .readyout_i(readyout_i), .resp_i(resp_i),
    .rdata_i(rdata_i), .ruser_i(ruser_i), .sel_o(ovl_sel_o), .active_o(ovl_active_o),
    .readyout_o(ovl_readyout_o), .resp_o(ovl_resp_o), .rdata_o(ovl_rdata_o),
    .ruser_o(ovl_ruser_o), .err_clr_i(err_clr_i), .err_valid_o(ovl_err_valid_o),
    .err_addr_o(ovl_err_addr_o)
  );

  function automatic logic [21:0] fld(input logic [31:0] a);
    return 22'(a >> 10);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    HRESETn = 1'b0; sel_i = 1'b0; addr_i = '0; trans_i = 2'b00; readys_i = 1'b1;
    active_i = 4'b0101; readyout_i = 4'hF; resp_i = 8'h00; err_clr_i = 1'b0;
    for (int p = 0; p < 4; p++) begin
      rdata_i[p*32 +: 32] = 32'hA000_0000 + 32'(p);
      ruser_i[p*32 +: 32] = 32'hB000_0000 + 32'(p);
    end
    #12;
    chk("rst_ready", {31'd0, readyout_o}, 32'd1);
    chk("rst_resp", {30'd0, resp_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_ruser", ruser_o, 32'd0);
    chk("rst_sel", {28'd0, sel_o}, 32'd0);
    chk("rst_errv", {31'd0, err_valid_o}, 32'd0);
    chk("rst_erra", {10'd0, err_addr_o}, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick();

    // Port 0 read
    sel_i = 1'b1; trans_i = 2'b10; addr_i = fld(32'h2000_0400); #1;
    chk("p0_sel", {28'd0, sel_o}, 32'h1);
    chk("p0_active", {31'd0, active_o}, 32'd1);
    chk("ovl_p0_sel", {28'd0, ovl_sel_o}, 32'h1);
    tick();
    sel_i = 1'b0; trans_i = 2'b00; #1;
    chk("p0_rdata", rdata_o, 32'hA000_0000);
    chk("p0_ruser", ruser_o, 32'hB000_0000);
    chk("p0_ready", {31'd0, readyout_o}, 32'd1);
    readyout_i = 4'b1110; #1;
    chk("p0_ready_low", {31'd0, readyout_o}, 32'd0);
    readyout_i = 4'hF;
    tick();

    // Region boundaries and overlap
    sel_i = 1'b1; trans_i = 2'b10;
    addr_i = fld(32'h2000_FFFF); #1;
    chk("lim0_in", {28'd0, sel_o}, 32'h1);
    addr_i = fld(32'h2001_0000); #1;
    chk("lim0_out", {28'd0, sel_o}, 32'h0);
    addr_i = fld(32'h2000_0000); #1;
    chk("ovl_lowest", {28'd0, ovl_sel_o}, 32'h1);
    addr_i = fld(32'h3000_0000); #1;
    chk("ovl_p1", {28'd0, ovl_sel_o}, 32'h2);

    // Unmapped single transfer
    chk("dft_sel", {28'd0, sel_o}, 32'h0);
    chk("dft_active", {31'd0, active_o}, 32'd1);
    tick();
    sel_i = 1'b0; trans_i = 2'b00; readys_i = 1'b0; #1;
    chk("err1_ready", {31'd0, readyout_o}, 32'd0);
    chk("err1_resp", {30'd0, resp_o}, 32'd1);
    chk("err1_rdata", rdata_o, 32'd0);
    tick();
    chk("err2_ready", {31'd0, readyout_o}, 32'd1);
    chk("err2_resp", {30'd0, resp_o}, 32'd1);
    chk("cap_valid", {31'd0, err_valid_o}, CAP ? 32'd1 : 32'd0);
    chk("cap_addr", {10'd0, err_addr_o}, CAP ? {10'd0, fld(32'h3000_0000)} : 32'd0);
    readys_i = 1'b1;
    tick();
    chk("err_done_resp", {30'd0, resp_o}, 32'd0);
    chk("err_done_ready", {31'd0, readyout_o}, 32'd1);

    // Back-to-back unmapped transfers, sticky capture, clear with simultaneous error
    sel_i = 1'b1; trans_i = 2'b10; addr_i = fld(32'h1000_0000);
    tick();
    readys_i = 1'b0; #1;
    chk("b2b_err1_ready", {31'd0, readyout_o}, 32'd0);
    chk("sticky_addr", {10'd0, err_addr_o}, CAP ? {10'd0, fld(32'h3000_0000)} : 32'd0);
    tick();
    chk("b2b_err2_resp", {30'd0, resp_o}, 32'd1);
    readys_i = 1'b1; err_clr_i = 1'b1; addr_i = fld(32'h0000_0400);
    tick();
    err_clr_i = 1'b0; sel_i = 1'b0; trans_i = 2'b00; readys_i = 1'b0; #1;
    chk("b2b_again_ready", {31'd0, readyout_o}, 32'd0);
    chk("b2b_again_resp", {30'd0, resp_o}, 32'd1);
    chk("recap_valid", {31'd0, err_valid_o}, CAP ? 32'd1 : 32'd0);
    chk("recap_addr", {10'd0, err_addr_o}, CAP ? 32'h1 : 32'd0);
    tick();
    readys_i = 1'b1;
    tick();
    chk("b2b_idle_resp", {30'd0, resp_o}, 32'd0);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0; #1;
    chk("clr_valid", {31'd0, err_valid_o}, 32'd0);

    // IDLE hold on port 1
    sel_i = 1'b1; trans_i = 2'b10; addr_i = fld(32'h4000_0000); #1;
    chk("p1_sel", {28'd0, sel_o}, 32'h2);
    chk("p1_active", {31'd0, active_o}, 32'd0);
    tick();
    trans_i = 2'b00; addr_i = '0; #1;
    chk("hold_sel", {28'd0, sel_o}, 32'h2);
    readyout_i = 4'b1101; #1;
    chk("hold_ready", {31'd0, readyout_o}, 32'd0);
    chk("hold_rdata", rdata_o, 32'hA000_0001);
    trans_i = 2'b10; #1;
    chk("nohold_sel", {28'd0, sel_o}, 32'h0);
    readyout_i = 4'hF; sel_i = 1'b0; trans_i = 2'b00;
    tick();

    // Port 3 with ERROR response
    resp_i = 8'b0100_0000; sel_i = 1'b1; trans_i = 2'b10; addr_i = fld(32'h5000_0000); #1;
    chk("p3_sel", {28'd0, sel_o}, 32'h8);
    tick();
    sel_i = 1'b0; trans_i = 2'b00; #1;
    chk("p3_resp", {30'd0, resp_o}, 32'd1);
    chk("p3_ruser", ruser_o, 32'hB000_0003);
    resp_i = 8'h00;
    tick();
    chk("none_resp", {30'd0, resp_o}, 32'd0);

    // Wait states on port 2, then asynchronous reset mid-transfer
    sel_i = 1'b1; trans_i = 2'b10; addr_i = fld(32'h6000_0000); #1;
    chk("p2_sel", {28'd0, sel_o}, 32'h4);
    tick();
    sel_i = 1'b0; trans_i = 2'b00; readyout_i = 4'b1011; readys_i = 1'b0; #1;
    chk("ws1_ready", {31'd0, readyout_o}, 32'd0);
    tick();
    chk("ws2_ready", {31'd0, readyout_o}, 32'd0);
    chk("ws2_rdata", rdata_o, 32'hA000_0002);
    HRESETn = 1'b0; #1;
    chk("arst_ready", {31'd0, readyout_o}, 32'd1);
    chk("arst_rdata", rdata_o, 32'd0);
    tick();
    HRESETn = 1'b1; readys_i = 1'b1; readyout_i = 4'hF;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
